// File: rtl/music_player_stream.sv
// Streams packed flash words through a two-slot prefetch buffer and emits one
// SAMPLE_W-bit lane per startsamplenow strobe, forward or backward over a wrapping address window.
module music_player_stream #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 32,
  parameter int SAMPLE_W = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  kybrd_forward,
  input  logic                  kybrd_pause,
  input  logic                  kybrd_restart,
  input  logic                  startsamplenow,
  output logic [ADDR_W-1:0]     flsh_address,
  output logic                  flsh_read,
  input  logic                  flsh_waitrequest,
  input  logic [DATA_W-1:0]     flsh_readdata,
  input  logic                  flsh_readdatavalid,
  output logic [DATA_W/8-1:0]   flsh_byteenable,
  output logic [SAMPLE_W-1:0]   audio_data,
  output logic                  audio_strobe,
  output logic                  underrun
);

  localparam int N      = DATA_W / SAMPLE_W;
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]          state, state_n;
  logic [ADDR_W-1:0]   ptr, addr;
  logic                req_dir, drop, read_q;

  logic                cur_valid, cur_valid_n;
  logic [DATA_W-1:0]   cur_word, cur_word_n;
  logic                cur_dir, cur_dir_n;
  logic [LANE_W-1:0]   cur_lane, cur_lane_n;
  logic                nxt_valid, nxt_valid_n;
  logic [DATA_W-1:0]   nxt_word, nxt_word_n;
  logic                nxt_dir, nxt_dir_n;

  logic                play, accept, capture, last_lane;
  logic [LANE_W-1:0]   lane_sel;
  logic [SAMPLE_W-1:0] sample;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic fwd);
    if (fwd)
      return (a == END_ADDR) ? START_ADDR : a + 1'b1;
    else
      return (a == START_ADDR) ? END_ADDR : a - 1'b1;
  endfunction

  // Restart overrides any sample request in the same cycle.
  assign play      = startsamplenow && !kybrd_pause && !kybrd_restart;
  assign accept    = (state == S_REQ) && !flsh_waitrequest;
  assign capture   = (state == S_WAIT) && flsh_readdatavalid && !drop && !kybrd_restart;
  assign last_lane = (cur_lane == LAST_LANE);
  assign lane_sel  = cur_dir ? cur_lane : LAST_LANE - cur_lane;
  assign sample    = cur_word[lane_sel*SAMPLE_W +: SAMPLE_W];

  assign flsh_address    = addr;
  assign flsh_read       = read_q;
  assign flsh_byteenable = '1;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (!kybrd_restart && !nxt_valid) state_n = S_REQ;
      S_REQ:   if (!flsh_waitrequest) state_n = S_WAIT;
      S_WAIT:  if (flsh_readdatavalid) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Consumption is applied before capture so a word arriving as CUR drains lands in CUR.
  always_comb begin
    cur_valid_n = cur_valid;
    cur_word_n  = cur_word;
    cur_dir_n   = cur_dir;
    cur_lane_n  = cur_lane;
    nxt_valid_n = nxt_valid;
    nxt_word_n  = nxt_word;
    nxt_dir_n   = nxt_dir;
    if (play && cur_valid) begin
      if (last_lane) begin
        cur_valid_n = nxt_valid;
        cur_word_n  = nxt_word;
        cur_dir_n   = nxt_dir;
        cur_lane_n  = '0;
        nxt_valid_n = 1'b0;
      end else begin
        cur_lane_n = cur_lane + 1'b1;
      end
    end
    if (capture) begin
      if (!cur_valid_n) begin
        cur_valid_n = 1'b1;
        cur_word_n  = flsh_readdata;
        cur_dir_n   = req_dir;
        cur_lane_n  = '0;
      end else begin
        nxt_valid_n = 1'b1;
        nxt_word_n  = flsh_readdata;
        nxt_dir_n   = req_dir;
      end
    end
    if (kybrd_restart) begin
      cur_valid_n = 1'b0;
      nxt_valid_n = 1'b0;
      cur_lane_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      read_q       <= 1'b0;
      addr         <= START_ADDR;
      ptr          <= START_ADDR;
      req_dir      <= 1'b1;
      drop         <= 1'b0;
      cur_valid    <= 1'b0;
      cur_word     <= '0;
      cur_dir      <= 1'b1;
      cur_lane     <= '0;
      nxt_valid    <= 1'b0;
      nxt_word     <= '0;
      nxt_dir      <= 1'b1;
      audio_data   <= '0;
      audio_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state  <= state_n;
      read_q <= (state_n == S_REQ);

      if (state == S_IDLE && state_n == S_REQ) begin
        addr    <= ptr;
        req_dir <= kybrd_forward;
      end

      // A request already committed when restart hit must not move the fresh pointer.
      if (kybrd_restart)
        ptr <= kybrd_forward ? START_ADDR : END_ADDR;
      else if (accept && !drop)
        ptr <= step_addr(addr, req_dir);

      if (kybrd_restart && (state == S_REQ || (state == S_WAIT && !flsh_readdatavalid)))
        drop <= 1'b1;
      else if (state == S_WAIT && flsh_readdatavalid)
        drop <= 1'b0;

      cur_valid <= cur_valid_n;
      cur_word  <= cur_word_n;
      cur_dir   <= cur_dir_n;
      cur_lane  <= cur_lane_n;
      nxt_valid <= nxt_valid_n;
      nxt_word  <= nxt_word_n;
      nxt_dir   <= nxt_dir_n;

      audio_strobe <= play && cur_valid;
      underrun     <= play && !cur_valid;
      if (play && cur_valid)
        audio_data <= sample;
    end
  end

endmodule

// File: tb/tb_music_player_stream.sv
// Directed bench for music_player_stream: a small Avalon flash model plus
// table-driven playback vectors and hand-written multi-cycle sequences.
module tb_music_player_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kybrd_forward = 1'b1;
  logic        kybrd_pause = 1'b0;
  logic        kybrd_restart = 1'b0;
  logic        startsamplenow = 1'b0;
  logic [22:0] flsh_address;
  logic        flsh_read;
  logic        flsh_waitrequest = 1'b0;
  logic [31:0] flsh_readdata = '0;
  logic        flsh_readdatavalid = 1'b0;
  logic [3:0]  flsh_byteenable;
  logic [15:0] audio_data;
  logic        audio_strobe;
  logic        underrun;

  int compared = 0;
  int failed = 0;

  logic [31:0] mem [4];
  int          lat = 3;
  int          stall_cfg = 0;
  int          resp_cnt = 0;
  int          stall_left = 0;
  logic        in_req = 1'b0;
  logic [31:0] resp_data = '0;
  int          accept_count = 0;
  logic [22:0] addr_log [$];

  typedef struct {
    logic        fwd;
    logic        pause;
    logic        restart;
    logic        start;
    logic        exp_strobe;
    logic        exp_under;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  music_player_stream #(
    .ADDR_W(23), .DATA_W(32), .SAMPLE_W(16),
    .START_ADDR(23'd0), .END_ADDR(23'd3)
  ) dut (
    .clk(clk), .reset(reset),
    .kybrd_forward(kybrd_forward), .kybrd_pause(kybrd_pause),
    .kybrd_restart(kybrd_restart), .startsamplenow(startsamplenow),
    .flsh_address(flsh_address), .flsh_read(flsh_read),
    .flsh_waitrequest(flsh_waitrequest), .flsh_readdata(flsh_readdata),
    .flsh_readdatavalid(flsh_readdatavalid), .flsh_byteenable(flsh_byteenable),
    .audio_data(audio_data), .audio_strobe(audio_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Flash slave: drives on the falling edge, optional stall, fixed read latency.
  always @(negedge clk) begin
    if (reset) begin
      flsh_waitrequest   = 1'b0;
      flsh_readdatavalid = 1'b0;
      flsh_readdata      = '0;
      resp_cnt     = 0;
      stall_left   = 0;
      in_req       = 1'b0;
      accept_count = 0;
      addr_log.delete();
    end else begin
      flsh_readdatavalid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          flsh_readdatavalid = 1'b1;
          flsh_readdata      = resp_data;
        end
      end
      if (flsh_read && !in_req) begin
        in_req     = 1'b1;
        stall_left = stall_cfg;
      end
      if (flsh_read && stall_left > 0) begin
        flsh_waitrequest = 1'b1;
        stall_left--;
      end else begin
        flsh_waitrequest = 1'b0;
        if (flsh_read) begin
          addr_log.push_back(flsh_address);
          resp_data = mem[flsh_address[1:0]];
          resp_cnt  = lat;
          accept_count++;
          in_req = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic fwd, input logic pause,
                               input logic restart, input logic start);
    @(negedge clk);
    kybrd_forward  = fwd;
    kybrd_pause    = pause;
    kybrd_restart  = restart;
    startsamplenow = start;
    @(posedge clk);
    #1;
    kybrd_restart  = 1'b0;
    startsamplenow = 1'b0;
  endtask

  task automatic resetHold(input logic fwd, input logic pause);
    @(negedge clk);
    reset          = 1'b1;
    kybrd_forward  = fwd;
    kybrd_pause    = pause;
    kybrd_restart  = 1'b0;
    startsamplenow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic resetRelease();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic playCheck(input string name, input logic [15:0] exp);
    applyStimulus(kybrd_forward, 1'b0, 1'b0, 1'b1);
    checkOutput({name, " strobe"}, {31'd0, audio_strobe}, 32'd1);
    checkOutput({name, " data"}, {16'd0, audio_data}, {16'd0, exp});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  read_highs;
    bit  seen;

    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h12345678;
    mem[2] = 32'hCAFEF00D;
    mem[3] = 32'hAAAA5555;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hDEAD};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h5678};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hF00D};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF00D};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hF00D};

    $display("[TB] reset state, forward");
    lat = 3;
    resetHold(1'b1, 1'b0);
    checkOutput("rst read", {31'd0, flsh_read}, 32'd0);
    checkOutput("rst addr", {9'd0, flsh_address}, 32'd0);
    checkOutput("rst data", {16'd0, audio_data}, 32'd0);
    checkOutput("rst strobe", {31'd0, audio_strobe}, 32'd0);
    checkOutput("rst underrun", {31'd0, underrun}, 32'd0);
    checkOutput("byteenable", {28'd0, flsh_byteenable}, 32'hF);
    resetRelease();
    idleCycles(1);
    checkOutput("first read", {31'd0, flsh_read}, 32'd1);
    checkOutput("first addr", {9'd0, flsh_address}, 32'd0);

    $display("[TB] underrun before first data");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("early underrun", {31'd0, underrun}, 32'd1);
    checkOutput("early strobe", {31'd0, audio_strobe}, 32'd0);
    checkOutput("early data", {16'd0, audio_data}, 32'd0);
    idleCycles(20);
    checkOutput("fill accepts", accept_count, 32'd2);
    checkOutput("fill read idle", {31'd0, flsh_read}, 32'd0);

    $display("[TB] playback vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].fwd, vecs[i].pause, vecs[i].restart, vecs[i].start);
      checkOutput($sformatf("vec%0d strobe", i), {31'd0, audio_strobe}, {31'd0, vecs[i].exp_strobe});
      checkOutput($sformatf("vec%0d underrun", i), {31'd0, underrun}, {31'd0, vecs[i].exp_under});
      checkOutput($sformatf("vec%0d data", i), {16'd0, audio_data}, {16'd0, vecs[i].exp_data});
    end
    checkOutput("fwd log size", (addr_log.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    checkOutput("fwd addr0", {9'd0, addr_log[0]}, 32'd0);
    checkOutput("fwd addr1", {9'd0, addr_log[1]}, 32'd1);
    checkOutput("fwd addr2", {9'd0, addr_log[2]}, 32'd2);

    $display("[TB] backward playback with wrap");
    resetHold(1'b0, 1'b0);
    checkOutput("rst2 data", {16'd0, audio_data}, 32'd0);
    checkOutput("rst2 read", {31'd0, flsh_read}, 32'd0);
    lat = 1;
    resetRelease();
    idleCycles(15);
    checkOutput("bwd fill size", addr_log.size(), 32'd2);
    checkOutput("bwd wrap addr", {9'd0, addr_log[1]}, 32'd3);
    playCheck("bwd s0", 16'hDEAD);
    playCheck("bwd s1", 16'hBEEF);
    playCheck("bwd s2", 16'hAAAA);
    playCheck("bwd s3", 16'h5555);
    idleCycles(15);
    playCheck("bwd s4", 16'hCAFE);
    playCheck("bwd s5", 16'hF00D);
    idleCycles(15);
    checkOutput("bwd log size", addr_log.size(), 32'd5);
    checkOutput("bwd addr2", {9'd0, addr_log[2]}, 32'd2);
    checkOutput("bwd addr3", {9'd0, addr_log[3]}, 32'd1);
    checkOutput("bwd addr4", {9'd0, addr_log[4]}, 32'd0);

    $display("[TB] waitrequest stall");
    resetHold(1'b1, 1'b0);
    stall_cfg = 5;
    lat = 2;
    resetRelease();
    idleCycles(1);
    for (int i = 0; i < 5; i++) begin
      idleCycles(1);
      checkOutput($sformatf("stall%0d read", i), {31'd0, flsh_read}, 32'd1);
      checkOutput($sformatf("stall%0d addr", i), {9'd0, flsh_address}, 32'd0);
      checkOutput($sformatf("stall%0d wait", i), {31'd0, flsh_waitrequest}, 32'd1);
    end
    stall_cfg = 0;
    idleCycles(1);
    checkOutput("stall released read", {31'd0, flsh_read}, 32'd0);
    checkOutput("stall accepts", accept_count, 32'd1);
    idleCycles(10);
    playCheck("stall play", 16'hBEEF);

    $display("[TB] pause");
    resetHold(1'b1, 1'b1);
    resetRelease();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("pause%0d strobe", i), {31'd0, audio_strobe}, 32'd0);
      checkOutput($sformatf("pause%0d underrun", i), {31'd0, underrun}, 32'd0);
      checkOutput($sformatf("pause%0d data", i), {16'd0, audio_data}, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    end
    idleCycles(20);
    checkOutput("pause accepts", accept_count, 32'd2);
    read_highs = 0;
    for (int i = 0; i < 10; i++) begin
      idleCycles(1);
      if (flsh_read) read_highs++;
    end
    checkOutput("pause read quiet", read_highs, 32'd0);

    $display("[TB] restart while waiting for data");
    resetHold(1'b1, 1'b0);
    lat = 4;
    mem[0] = 32'h11112222;
    resetRelease();
    idleCycles(2);
    mem[0] = 32'h33334444;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("restart read", {31'd0, flsh_read}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idleCycles(1);
      if (flsh_readdatavalid) seen = 1'b1;
    end
    checkOutput("restart resp seen", {31'd0, seen}, 32'd1);
    checkOutput("restart single read", accept_count, 32'd1);
    idleCycles(20);
    checkOutput("restart log size", (addr_log.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
    checkOutput("restart addr", {9'd0, addr_log[1]}, 32'd0);
    playCheck("restart play", 16'h4444);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
